// File: rtl/mem_access_stage.sv
// Memory-access stage: issues one word load/store per instruction to the cache
// over a req/ready handshake, stalling upstream until the cache responds or times out.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  CacheReady,
  input  logic [DATA_WIDTH-1:0] CacheRData,
  output logic                  CacheReq,
  output logic                  CacheWE,
  output logic [ADDR_WIDTH-1:0] CacheAddr,
  output logic [DATA_WIDTH-1:0] CacheWData,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  DataValid,
  output logic                  MisalignedFault,
  output logic                  BusError
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 acc, aligned, accept;

  assign acc     = MemRead | MemWrite;
  assign aligned = (ALUResult[1:0] == 2'b00);
  assign accept  = (state == IDLE) && acc && aligned;

  // Misaligned accesses are rejected without a request, so they never stall.
  assign Stall           = accept || (state == REQ);
  assign MisalignedFault = (state == IDLE) && acc && !aligned;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = REQ;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        // A ready response on the final timeout cycle still completes the access.
        if (CacheReady)
          state_nxt = DONE;
        else if (cnt == CNT_LAST)
          state_nxt = ERR;
        else
          cnt_nxt = cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      CacheReq   <= 1'b0;
      CacheWE    <= 1'b0;
      CacheAddr  <= '0;
      CacheWData <= '0;
      ReadData   <= '0;
      DataValid  <= 1'b0;
      BusError   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      CacheReq  <= (state_nxt == REQ);
      DataValid <= (state_nxt == DONE);
      BusError  <= (state_nxt == ERR);
      if (accept) begin
        CacheAddr  <= ALUResult;
        CacheWData <= WriteData;
        CacheWE    <= MemWrite;
      end
      if ((state == REQ) && CacheReady && !CacheWE)
        ReadData <= CacheRData;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of complete accesses plus
// hand-written timeout, reset-abort and back-to-back sequences.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult, WriteData, CacheRData;
  logic        MemRead, MemWrite, CacheReady;
  logic        CacheReq, CacheWE, Stall, DataValid, MisalignedFault, BusError;
  logic [31:0] CacheAddr, CacheWData, ReadData;

  int n_cmp = 0;
  int n_bad = 0;

  mem_access_stage #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .CacheReady(CacheReady),
    .CacheRData(CacheRData), .CacheReq(CacheReq), .CacheWE(CacheWE),
    .CacheAddr(CacheAddr), .CacheWData(CacheWData), .Stall(Stall),
    .ReadData(ReadData), .DataValid(DataValid),
    .MisalignedFault(MisalignedFault), .BusError(BusError)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_fault;
    logic        exp_we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic do_access(input int k);
    vec_t v;
    v = vecs[k];
    ALUResult = v.addr; WriteData = v.wdata; MemRead = v.rd; MemWrite = v.wr;
    CacheReady = 1'b0; CacheRData = 32'h0;
    half();
    chk($sformatf("v%0d fault", k), 32'(MisalignedFault), 32'(v.exp_fault));
    chk($sformatf("v%0d stall_idle", k), 32'(Stall), 32'(!v.exp_fault));
    chk($sformatf("v%0d req_idle", k), 32'(CacheReq), 32'h0);
    step();
    MemRead = 1'b0; MemWrite = 1'b0;
    if (v.exp_fault) begin
      chk($sformatf("v%0d req_after_fault", k), 32'(CacheReq), 32'h0);
      chk($sformatf("v%0d stall_after_fault", k), 32'(Stall), 32'h0);
      chk($sformatf("v%0d rd_after_fault", k), ReadData, v.exp_rd);
      return;
    end
    for (int i = 0; i <= v.waits; i++) begin
      // Inputs are scrambled during REQ; the latched request must not move.
      ALUResult = 32'hFFFF_FFF0 ^ 32'(i); WriteData = 32'h0BAD_0000 + 32'(i);
      MemWrite = (i < v.waits); MemRead = (i < v.waits);
      CacheReady = (i == v.waits); CacheRData = v.rdata;
      half();
      chk($sformatf("v%0d req%0d", k, i), 32'(CacheReq), 32'h1);
      chk($sformatf("v%0d stall%0d", k, i), 32'(Stall), 32'h1);
      chk($sformatf("v%0d addr%0d", k, i), CacheAddr, v.addr);
      chk($sformatf("v%0d we%0d", k, i), 32'(CacheWE), 32'(v.exp_we));
      if (v.exp_we) chk($sformatf("v%0d wdata%0d", k, i), CacheWData, v.wdata);
      step();
    end
    MemRead = 1'b0; MemWrite = 1'b0; CacheReady = 1'b0; CacheRData = 32'h0;
    half();
    chk($sformatf("v%0d done_valid", k), 32'(DataValid), 32'h1);
    chk($sformatf("v%0d done_stall", k), 32'(Stall), 32'h0);
    chk($sformatf("v%0d done_req", k), 32'(CacheReq), 32'h0);
    chk($sformatf("v%0d done_buserr", k), 32'(BusError), 32'h0);
    chk($sformatf("v%0d readdata", k), ReadData, v.exp_rd);
    step();
    chk($sformatf("v%0d idle_valid", k), 32'(DataValid), 32'h0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h204, 32'h12345678, 32'h0,        3, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b0, 32'h102, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'h300, 32'h000055AA, 32'h1111,     1, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h207, 32'h77,       32'h0,        0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h010, 32'h0,        32'h0000000A, 0, 1'b0, 1'b0, 32'h0000000A};
    vecs[6] = '{1'b0, 1'b1, 32'h014, 32'hBEEF0014, 32'h0,        0, 1'b0, 1'b1, 32'h0000000A};

    rst = 1'b1; ALUResult = 32'h0; WriteData = 32'h0; MemRead = 1'b0; MemWrite = 1'b0;
    CacheReady = 1'b0; CacheRData = 32'h0;
    repeat (2) @(posedge clk);
    half();
    chk("rst req", 32'(CacheReq), 32'h0);
    chk("rst we", 32'(CacheWE), 32'h0);
    chk("rst addr", CacheAddr, 32'h0);
    chk("rst wdata", CacheWData, 32'h0);
    chk("rst rdata", ReadData, 32'h0);
    chk("rst valid", 32'(DataValid), 32'h0);
    chk("rst buserr", 32'(BusError), 32'h0);
    chk("rst stall", 32'(Stall), 32'h0);
    rst = 1'b0;
    step();

    for (int k = 0; k < 7; k++) do_access(k);

    // Timeout: ready never arrives, request held for exactly 16 cycles.
    ALUResult = 32'h400; MemRead = 1'b1;
    step();
    MemRead = 1'b0;
    n = 0;
    while (CacheReq && n < 40) begin
      chk("to stall", 32'(Stall), 32'h1);
      n++;
      step();
    end
    chk("to req_cycles", 32'(n), 32'd16);
    chk("to buserr", 32'(BusError), 32'h1);
    chk("to err_stall", 32'(Stall), 32'h0);
    chk("to err_valid", 32'(DataValid), 32'h0);
    chk("to rdata_kept", ReadData, 32'h0000000A);
    step();
    chk("to buserr_pulse", 32'(BusError), 32'h0);
    chk("to idle_req", 32'(CacheReq), 32'h0);

    // Ready on the final (16th) REQ cycle: ready wins over timeout.
    ALUResult = 32'h404; MemRead = 1'b1;
    step();
    MemRead = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("edge req%0d", i), 32'(CacheReq), 32'h1);
      step();
    end
    CacheReady = 1'b1; CacheRData = 32'hCAFE0016;
    half();
    chk("edge req16", 32'(CacheReq), 32'h1);
    step();
    CacheReady = 1'b0;
    chk("edge valid", 32'(DataValid), 32'h1);
    chk("edge buserr", 32'(BusError), 32'h0);
    chk("edge rdata", ReadData, 32'hCAFE0016);
    step();

    // Reset during the second REQ cycle abandons the access.
    ALUResult = 32'h500; MemRead = 1'b1;
    step();
    MemRead = 1'b0;
    chk("ra req1", 32'(CacheReq), 32'h1);
    step();
    chk("ra req2", 32'(CacheReq), 32'h1);
    #2 rst = 1'b1;
    CacheReady = 1'b1; CacheRData = 32'h0BADBAD0;
    #1;
    chk("ra req_async", 32'(CacheReq), 32'h0);
    chk("ra stall", 32'(Stall), 32'h0);
    chk("ra addr", CacheAddr, 32'h0);
    chk("ra rdata", ReadData, 32'h0);
    half();
    rst = 1'b0;
    CacheReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ra valid%0d", i), 32'(DataValid), 32'h0);
      chk($sformatf("ra buserr%0d", i), 32'(BusError), 32'h0);
    end
    vecs[0] = '{1'b1, 1'b0, 32'h600, 32'h0, 32'h0000600D, 1, 1'b0, 1'b0, 32'h0000600D};
    do_access(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
